dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port, word-indexed data memory (1024 x 32).
- Port A is the pipeline MEM stage; port B is a secondary master (debug/loader/DMA).
- Grants one access per cycle with round-robin fairness and optional lock for multi-word sequences.
- Translates byte addresses to word indices, filters illegal accesses, and returns registered read data with a valid pulse.

---
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-master arbiter and sequencer in front of the single-port data memory.
//   Port A is the pipeline MEM stage. Port B is a secondary master
//   (debug/loader/DMA). The block grants one access per cycle using
//   round-robin. A master that holds its lock input keeps the grant across
//   cycles. Byte addresses become word indices here, and illegal accesses are
//   filtered out. Each granted read returns registered data together with a
//   one-cycle valid pulse.
//
// Ports
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   a_*/b_* req/we/lock    request, write enable, lock-hold request
//   a_*/b_* addr/wdata     byte address, write data
//   a_*/b_* gnt            access accepted this cycle (combinational)
//   a_*/b_* rdata/rvalid   read data (registered) and its one-cycle valid
//   a_*/b_* err            one-cycle pulse: previous granted access was illegal
//   mem_idx/wdata/we       word-indexed memory drive
//   mem_rdata              combinational read data from memory
//
// state  | meaning
// -------+-------------------------------------------------------------
// ARB    | round-robin arbitration between A and B using lastB
// LOCK_A | A holds the grant; B is blocked until A drops lock or req
// LOCK_B | B holds the grant; A is blocked until B drops lock or req

module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  output logic              a_err,

  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              b_err,

  output logic [IDX_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arbState_t;

  localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(DEPTH);

  arbState_t state;
  arbState_t nextState;
  logic      lastB;
  logic      aGnt;
  logic      bGnt;
  logic      aLegal;
  logic      bLegal;
  logic      aRead;
  logic      bRead;

  // Word-aligned and inside the memory. Anything else is still granted, but it
  // is consumed without touching memory.
  assign aLegal = (a_addr[1:0] == 2'b00) && (a_addr[ADDR_W-1:2] < DEPTH_WORDS);
  assign bLegal = (b_addr[1:0] == 2'b00) && (b_addr[ADDR_W-1:2] < DEPTH_WORDS);

  always_comb begin
    nextState = state;
    aGnt      = 1'b0;
    bGnt      = 1'b0;

    case (state)
      ARB: begin
        if (a_req && b_req) begin
          aGnt = lastB;
          bGnt = ~lastB;
        end else begin
          aGnt = a_req;
          bGnt = b_req;
        end
        if (aGnt && a_lock) begin
          nextState = LOCK_A;
        end else if (bGnt && b_lock) begin
          nextState = LOCK_B;
        end
      end

      // The exit cycle is still served under lock rules. Normal arbitration
      // resumes on the following cycle.
      LOCK_A: begin
        aGnt = a_req;
        if (!a_req || !a_lock) begin
          nextState = ARB;
        end
      end

      LOCK_B: begin
        bGnt = b_req;
        if (!b_req || !b_lock) begin
          nextState = ARB;
        end
      end

      default: begin
        nextState = ARB;
      end
    endcase

    // No access may reach memory while the block is held in reset.
    if (!RST_N) begin
      aGnt = 1'b0;
      bGnt = 1'b0;
    end
  end

  assign a_gnt = aGnt;
  assign b_gnt = bGnt;
  assign aRead = aGnt & ~a_we;
  assign bRead = bGnt & ~b_we;

  always_comb begin
    mem_idx   = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (aGnt) begin
      mem_idx   = a_addr[IDX_W+1:2];
      mem_wdata = a_wdata;
      mem_we    = a_we & aLegal;
    end else if (bGnt) begin
      mem_idx   = b_addr[IDX_W+1:2];
      mem_wdata = b_wdata;
      mem_we    = b_we & bLegal;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ARB;
      lastB <= 1'b1;
    end else begin
      state <= nextState;
      if (aGnt) begin
        lastB <= 1'b0;
      end else if (bGnt) begin
        lastB <= 1'b1;
      end
    end
  end

  // Response registers. Each register holds rdata until the next granted read
  // on the same port. An illegal read returns zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      a_rvalid <= aRead;
      a_err    <= aGnt & ~aLegal;
      if (aRead) begin
        a_rdata <= aLegal ? mem_rdata : '0;
      end
      b_rvalid <= bRead;
      b_err    <= bGnt & ~bLegal;
      if (bRead) begin
        b_rdata <= bLegal ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. It holds a 1024-word memory model behind
//   the arbiter. Grants and the memory drive are checked in the grant cycle.
//   The expected response of each cycle is queued and then compared one cycle
//   later.

module tb_dmem_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        a_req, a_we, a_lock;
  logic [31:0] a_addr, a_wdata;
  logic        a_gnt, a_rvalid, a_err;
  logic [31:0] a_rdata;
  logic        b_req, b_we, b_lock;
  logic [31:0] b_addr, b_wdata;
  logic        b_gnt, b_rvalid, b_err;
  logic [31:0] b_rdata;
  logic [9:0]  mem_idx;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] memArr [0:1023];

  typedef struct {
    logic        aV;
    logic        aE;
    logic [31:0] aD;
    logic        bV;
    logic        bE;
    logic [31:0] bD;
  } resp_t;

  resp_t       respQ[$];
  logic [31:0] expAHold;
  logic [31:0] expBHold;
  int          nChecks;
  int          nPass;
  int          nFail;

  dmem_arbiter dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_lock    (a_lock),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rdata   (a_rdata),
    .a_rvalid  (a_rvalid),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_lock    (b_lock),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rdata   (b_rdata),
    .b_rvalid  (b_rvalid),
    .b_err     (b_err),
    .mem_idx   (mem_idx),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign mem_rdata = memArr[mem_idx];

  always @(posedge CLK) begin
    if (mem_we) memArr[mem_idx] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr[31:2] < 30'd1024);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResp();
    resp_t r;
    if (respQ.size() == 0) begin
      nChecks++;
      nFail++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      r = respQ.pop_front();
      check("a_rvalid", 32'(a_rvalid), 32'(r.aV));
      check("a_err",    32'(a_err),    32'(r.aE));
      check("a_rdata",  a_rdata,       r.aD);
      check("b_rvalid", 32'(b_rvalid), 32'(r.bV));
      check("b_err",    32'(b_err),    32'(r.bE));
      check("b_rdata",  b_rdata,       r.bD);
    end
  endtask

  task automatic pushNone();
    resp_t r;
    r.aV = 1'b0; r.aE = 1'b0; r.aD = expAHold;
    r.bV = 1'b0; r.bE = 1'b0; r.bD = expBHold;
    respQ.push_back(r);
  endtask

  // One clock cycle. Drive the inputs, check the previous cycle's response,
  // check this cycle's grant and memory drive, then queue the expected
  // response for the next cycle.
  task automatic step(input logic aR, input logic aW, input logic aL,
                      input logic [31:0] aAd, input logic [31:0] aWd,
                      input logic bR, input logic bW, input logic bL,
                      input logic [31:0] bAd, input logic [31:0] bWd,
                      input logic eA, input logic eB,
                      input logic [31:0] eAD, input logic [31:0] eBD);
    resp_t       r;
    logic [9:0]  eIdx;
    logic        eWe;
    logic [31:0] eWd;
    a_req = aR; a_we = aW; a_lock = aL; a_addr = aAd; a_wdata = aWd;
    b_req = bR; b_we = bW; b_lock = bL; b_addr = bAd; b_wdata = bWd;
    @(negedge CLK);
    checkResp();
    check("a_gnt", 32'(a_gnt), 32'(eA));
    check("b_gnt", 32'(b_gnt), 32'(eB));
    eIdx = '0; eWe = 1'b0; eWd = '0;
    if (eA) begin
      eIdx = aAd[11:2]; eWe = aW && legal(aAd); eWd = aWd;
    end else if (eB) begin
      eIdx = bAd[11:2]; eWe = bW && legal(bAd); eWd = bWd;
    end
    check("mem_idx",   32'(mem_idx), 32'(eIdx));
    check("mem_we",    32'(mem_we),  32'(eWe));
    check("mem_wdata", mem_wdata,    eWd);
    r.aV = eA && !aW;
    r.aE = eA && !legal(aAd);
    r.aD = r.aV ? eAD : expAHold;
    expAHold = r.aD;
    r.bV = eB && !bW;
    r.bE = eB && !legal(bAd);
    r.bD = r.bV ? eBD : expBHold;
    expBHold = r.bD;
    respQ.push_back(r);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    nChecks = 0; nPass = 0; nFail = 0;
    expAHold = '0; expBHold = '0;
    for (int i = 0; i < 1024; i++) memArr[i] = 32'hA500_0000 | i;

    // Reset with both ports requesting: the grants and write enable must be
    // forced off.
    RST_N = 1'b0;
    a_req = 1; a_we = 1; a_lock = 1; a_addr = 32'h10; a_wdata = 32'h1;
    b_req = 1; b_we = 1; b_lock = 0; b_addr = 32'h20; b_wdata = 32'h2;
    #2;
    check("rst a_gnt",    32'(a_gnt),    32'h0);
    check("rst b_gnt",    32'(b_gnt),    32'h0);
    check("rst mem_we",   32'(mem_we),   32'h0);
    check("rst a_rvalid", 32'(a_rvalid), 32'h0);
    check("rst a_err",    32'(a_err),    32'h0);
    check("rst a_rdata",  a_rdata,       32'h0);
    check("rst b_rdata",  b_rdata,       32'h0);
    a_req = 0; a_we = 0; a_lock = 0; b_req = 0; b_we = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    pushNone();

    // A writes 0xDEADBEEF at 0x10 and then reads it back.
    step(1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hDEADBEEF, 32'h0);
    idle();

    // B reads alone, so B becomes the last winner. A then wins the contention.
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0, 0, 1, 32'h0, 32'hA5000008);
    step(1, 0, 0, 32'h100, 32'h0, 1, 0, 0, 32'h200, 32'h0, 1, 0, 32'hA5000040, 32'h0);
    step(1, 0, 0, 32'h100, 32'h0, 1, 0, 0, 32'h200, 32'h0, 0, 1, 32'h0, 32'hA5000080);
    step(1, 0, 0, 32'h100, 32'h0, 1, 0, 0, 32'h200, 32'h0, 1, 0, 32'hA5000040, 32'h0);
    step(1, 0, 0, 32'h100, 32'h0, 1, 0, 0, 32'h200, 32'h0, 0, 1, 32'h0, 32'hA5000080);

    // A wins alone, then B locks for 3 cycles while A keeps requesting.
    step(1, 0, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hA5000041, 32'h0);
    step(1, 0, 0, 32'h104, 32'h0, 1, 0, 1, 32'h204, 32'h0, 0, 1, 32'h0, 32'hA5000081);
    step(1, 0, 0, 32'h104, 32'h0, 1, 0, 1, 32'h204, 32'h0, 0, 1, 32'h0, 32'hA5000081);
    step(1, 0, 0, 32'h104, 32'h0, 1, 0, 1, 32'h204, 32'h0, 0, 1, 32'h0, 32'hA5000081);
    step(1, 0, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hA5000041, 32'h0);

    // Illegal accesses: a misaligned read, then an out-of-range write.
    step(1, 0, 0, 32'h12,   32'h0,        0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
    step(1, 1, 0, 32'h1000, 32'h12345678, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
    idle();
    check("mem[0] untouched", memArr[0], 32'hA5000000);

    // A enters LOCK_A. Reset is then asserted in a cycle where A holds a
    // granted read.
    step(1, 0, 1, 32'h104, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hA5000041, 32'h0);
    a_req = 1; a_we = 0; a_lock = 1; a_addr = 32'h108; a_wdata = 32'h0;
    b_req = 1; b_we = 0; b_lock = 0; b_addr = 32'h208; b_wdata = 32'h0;
    @(negedge CLK);
    checkResp();
    check("lockA a_gnt", 32'(a_gnt), 32'h1);
    check("lockA b_gnt", 32'(b_gnt), 32'h0);
    RST_N = 1'b0;
    #1;
    check("rst2 a_gnt",    32'(a_gnt),    32'h0);
    check("rst2 mem_we",   32'(mem_we),   32'h0);
    check("rst2 a_rvalid", 32'(a_rvalid), 32'h0);
    check("rst2 a_rdata",  a_rdata,       32'h0);
    respQ.delete();
    expAHold = '0; expBHold = '0;
    a_req = 0; a_lock = 0; b_req = 0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rel a_rvalid", 32'(a_rvalid), 32'h0);
    @(posedge CLK);
    #1;
    pushNone();
    // Back in ARB: B is served alone, and A wins the next contention.
    step(0, 0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h208, 32'h0, 0, 1, 32'h0, 32'hA5000082);
    step(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h208, 32'h0, 1, 0, 32'hDEADBEEF, 32'h0);

    // B writes and then reads the last word.
    step(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'hFFC, 32'h55, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'hFFC, 32'h0,  0, 1, 32'h0, 32'h55);
    idle();
    check("mem[1023]", memArr[1023], 32'h55);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
